// File: rtl/nanosoc_ahb_pkg.sv
// Shared AHB-Lite encodings and the region-slice state encoding.
package nanosoc_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DATA  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR1  = 3'd4,
    ST_ERR2  = 3'd5
  } slice_state_t;

endpackage

// File: rtl/nanosoc_ahb_region_slice.sv
// AHB-Lite register slice in front of a nanosoc region: registers address phase and response,
// converts every transfer to SINGLE/NONSEQ, and replays a two-cycle ERROR upstream.
module nanosoc_ahb_region_slice
  import nanosoc_ahb_pkg::*;
#(
  parameter int SYS_ADDR_W = 32,
  parameter int SYS_DATA_W = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL_S,
  input  logic [SYS_ADDR_W-1:0] HADDR_S,
  input  logic [2:0]            HBURST_S,
  input  logic                  HMASTLOCK_S,
  input  logic [3:0]            HPROT_S,
  input  logic [2:0]            HSIZE_S,
  input  logic [1:0]            HTRANS_S,
  input  logic                  HWRITE_S,
  input  logic [SYS_DATA_W-1:0] HWDATA_S,
  input  logic                  HREADY_S,
  output logic [SYS_DATA_W-1:0] HRDATA_S,
  output logic                  HRESP_S,
  output logic                  HREADYOUT_S,
  output logic                  HSEL_M,
  output logic [SYS_ADDR_W-1:0] HADDR_M,
  output logic [2:0]            HBURST_M,
  output logic                  HMASTLOCK_M,
  output logic [3:0]            HPROT_M,
  output logic [2:0]            HSIZE_M,
  output logic [1:0]            HTRANS_M,
  output logic                  HWRITE_M,
  output logic [SYS_DATA_W-1:0] HWDATA_M,
  output logic                  HREADY_M,
  input  logic [SYS_DATA_W-1:0] HRDATA_M,
  input  logic                  HRESP_M,
  input  logic                  HREADYOUT_M
);

  slice_state_t state_q, state_d;

  logic [SYS_ADDR_W-1:0] addr_p0;
  logic [2:0]            size_p0;
  logic [3:0]            prot_p0;
  logic                  write_p0;
  logic                  lock_p0;
  logic [SYS_DATA_W-1:0] wdata_p1;
  logic [SYS_DATA_W-1:0] rdata_p2;

  logic accept;
  logic cap_addr;
  logic cap_wdata;
  logic cap_rdata;

  // Burst type and the NONSEQ/SEQ distinction are deliberately dropped.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST_S, HTRANS_S[0]};

  assign accept = HSEL_S & HREADY_S & HTRANS_S[1];

  always_comb begin
    state_d     = state_q;
    HREADYOUT_S = 1'b1;
    HRESP_S     = HRESP_OKAY;
    HSEL_M      = 1'b0;
    HTRANS_M    = HTRANS_IDLE;
    HREADY_M    = 1'b1;
    cap_addr    = 1'b0;
    cap_wdata   = 1'b0;
    cap_rdata   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cap_addr = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        HREADYOUT_S = 1'b0;
        HSEL_M      = 1'b1;
        HTRANS_M    = HTRANS_NONSEQ;
        cap_wdata   = 1'b1;
        state_d     = ST_DATA;
      end
      ST_DATA: begin
        HREADYOUT_S = 1'b0;
        HREADY_M    = HREADYOUT_M;
        if (HREADYOUT_M) begin
          if (HRESP_M) begin
            state_d = ST_ERR1;
          end else begin
            cap_rdata = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        cap_addr = accept;
        state_d  = accept ? ST_ISSUE : ST_IDLE;
      end
      ST_ERR1: begin
        HRESP_S     = HRESP_ERROR;
        HREADYOUT_S = 1'b0;
        state_d     = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP_S  = HRESP_ERROR;
        cap_addr = accept;
        state_d  = accept ? ST_ISSUE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // p0: upstream address phase
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_p0  <= '0;
      size_p0  <= '0;
      prot_p0  <= '0;
      write_p0 <= 1'b0;
      lock_p0  <= 1'b0;
    end else if (cap_addr) begin
      addr_p0  <= HADDR_S;
      size_p0  <= HSIZE_S;
      prot_p0  <= HPROT_S;
      write_p0 <= HWRITE_S;
      lock_p0  <= HMASTLOCK_S;
    end
  end

  // p1: upstream write data, valid during ISSUE and held through DATA
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wdata_p1 <= '0;
    end else if (cap_wdata) begin
      wdata_p1 <= HWDATA_S;
    end
  end

  // p2: region read data
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rdata_p2 <= '0;
    end else if (cap_rdata) begin
      rdata_p2 <= HRDATA_M;
    end
  end

  assign HADDR_M     = addr_p0;
  assign HSIZE_M     = size_p0;
  assign HPROT_M     = prot_p0;
  assign HWRITE_M    = write_p0;
  assign HMASTLOCK_M = lock_p0;
  assign HBURST_M    = HBURST_SINGLE;
  assign HWDATA_M    = wdata_p1;
  assign HRDATA_S    = rdata_p2;

endmodule

// File: tb/tb_nanosoc_ahb_region_slice.sv
// Directed bench for the AHB region slice: read, waited write, error replay, burst split,
// mid-transfer reset and ignored transfers.
module tb_nanosoc_ahb_region_slice;
  import nanosoc_ahb_pkg::*;

  logic        HCLK;
  logic        HRESET;
  logic        HSEL_S;
  logic [31:0] HADDR_S;
  logic [2:0]  HBURST_S;
  logic        HMASTLOCK_S;
  logic [3:0]  HPROT_S;
  logic [2:0]  HSIZE_S;
  logic [1:0]  HTRANS_S;
  logic        HWRITE_S;
  logic [31:0] HWDATA_S;
  logic        HREADY_S;
  logic [31:0] HRDATA_S;
  logic        HRESP_S;
  logic        HREADYOUT_S;
  logic        HSEL_M;
  logic [31:0] HADDR_M;
  logic [2:0]  HBURST_M;
  logic        HMASTLOCK_M;
  logic [3:0]  HPROT_M;
  logic [2:0]  HSIZE_M;
  logic [1:0]  HTRANS_M;
  logic        HWRITE_M;
  logic [31:0] HWDATA_M;
  logic        HREADY_M;
  logic [31:0] HRDATA_M;
  logic        HRESP_M;
  logic        HREADYOUT_M;

  int total = 0;
  int bad   = 0;

  nanosoc_ahb_region_slice #(.SYS_ADDR_W(32), .SYS_DATA_W(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .HSEL_S(HSEL_S), .HADDR_S(HADDR_S), .HBURST_S(HBURST_S), .HMASTLOCK_S(HMASTLOCK_S),
    .HPROT_S(HPROT_S), .HSIZE_S(HSIZE_S), .HTRANS_S(HTRANS_S), .HWRITE_S(HWRITE_S),
    .HWDATA_S(HWDATA_S), .HREADY_S(HREADY_S), .HRDATA_S(HRDATA_S), .HRESP_S(HRESP_S),
    .HREADYOUT_S(HREADYOUT_S),
    .HSEL_M(HSEL_M), .HADDR_M(HADDR_M), .HBURST_M(HBURST_M), .HMASTLOCK_M(HMASTLOCK_M),
    .HPROT_M(HPROT_M), .HSIZE_M(HSIZE_M), .HTRANS_M(HTRANS_M), .HWRITE_M(HWRITE_M),
    .HWDATA_M(HWDATA_M), .HREADY_M(HREADY_M), .HRDATA_M(HRDATA_M), .HRESP_M(HRESP_M),
    .HREADYOUT_M(HREADYOUT_M)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic up_idle();
    HSEL_S   = 1'b0;
    HTRANS_S = HTRANS_IDLE;
    HBURST_S = 3'b000;
  endtask

  task automatic up_addr(input logic [31:0] a, input logic w, input logic [1:0] tr, input logic [2:0] b);
    HSEL_S   = 1'b1;
    HADDR_S  = a;
    HWRITE_S = w;
    HTRANS_S = tr;
    HBURST_S = b;
  endtask

  // Zero-wait single read; starts and ends with the slice in IDLE.
  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] d);
    up_addr(a, 1'b0, HTRANS_NONSEQ, 3'b000);
    #1;
    check({tag, "_t0_rdy"}, 32'(HREADYOUT_S), 32'd1);
    tick();
    up_idle();
    HREADYOUT_M = 1'b1;
    HRESP_M     = 1'b0;
    HRDATA_M    = d;
    #1;
    check({tag, "_t1_rdy"},   32'(HREADYOUT_S), 32'd0);
    check({tag, "_t1_sel"},   32'(HSEL_M),      32'd1);
    check({tag, "_t1_trans"}, 32'(HTRANS_M),    32'(HTRANS_NONSEQ));
    check({tag, "_t1_addr"},  HADDR_M,          a);
    check({tag, "_t1_write"}, 32'(HWRITE_M),    32'd0);
    tick();
    #1;
    check({tag, "_t2_rdy"}, 32'(HREADYOUT_S), 32'd0);
    check({tag, "_t2_sel"}, 32'(HSEL_M),      32'd0);
    tick();
    #1;
    check({tag, "_t3_rdy"},   32'(HREADYOUT_S), 32'd1);
    check({tag, "_t3_resp"},  32'(HRESP_S),     32'd0);
    check({tag, "_t3_rdata"}, HRDATA_S,         d);
    tick();
  endtask

  initial begin
    int waits;
    HRESET = 1'b1;
    up_idle();
    HADDR_S = '0; HMASTLOCK_S = 1'b0; HPROT_S = 4'h3; HSIZE_S = 3'b010;
    HWRITE_S = 1'b0; HWDATA_S = '0; HREADY_S = 1'b1;
    HRDATA_M = '0; HRESP_M = 1'b0; HREADYOUT_M = 1'b1;
    tick();
    tick();
    HRESET = 1'b0;
    #1;
    check("rst_rdy",   32'(HREADYOUT_S), 32'd1);
    check("rst_resp",  32'(HRESP_S),     32'd0);
    check("rst_sel",   32'(HSEL_M),      32'd0);
    check("rst_trans", 32'(HTRANS_M),    32'd0);
    check("rst_hrdym", 32'(HREADY_M),    32'd1);
    check("rst_rdata", HRDATA_S,         32'd0);
    check("rst_addr",  HADDR_M,          32'd0);
    check("rst_burst", 32'(HBURST_M),    32'd0);

    // zero-wait read
    do_read("rd", 32'hF000_0FFC, 32'h0000_000D);

    // write with 3 region wait states
    up_addr(32'hF000_0000, 1'b1, HTRANS_NONSEQ, 3'b000);
    tick();
    up_idle();
    HWDATA_S = 32'hDEAD_BEEF;
    HREADYOUT_M = 1'b1;
    #1;
    waits = (HREADYOUT_S == 1'b0) ? 1 : 0;
    check("wr_issue_write", 32'(HWRITE_M), 32'd1);
    tick();
    HWDATA_S = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      HREADYOUT_M = (i == 3);
      #1;
      if (HREADYOUT_S == 1'b0) waits++;
      check($sformatf("wr_wdata_%0d", i), HWDATA_M, 32'hDEAD_BEEF);
      check($sformatf("wr_hrdym_%0d", i), 32'(HREADY_M), (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    #1;
    check("wr_waits", 32'(waits), 32'd5);
    check("wr_done_rdy", 32'(HREADYOUT_S), 32'd1);
    tick();

    // two-cycle error replay
    up_addr(32'hF000_0040, 1'b0, HTRANS_NONSEQ, 3'b000);
    tick();
    up_idle();
    tick();
    HREADYOUT_M = 1'b0; HRESP_M = 1'b1;
    #1;
    check("err_d1_resp", 32'(HRESP_S),     32'd0);
    check("err_d1_rdy",  32'(HREADYOUT_S), 32'd0);
    tick();
    HREADYOUT_M = 1'b1; HRESP_M = 1'b1;
    tick();
    HRESP_M = 1'b0;
    #1;
    check("err1_resp", 32'(HRESP_S),     32'd1);
    check("err1_rdy",  32'(HREADYOUT_S), 32'd0);
    tick();
    #1;
    check("err2_resp", 32'(HRESP_S),     32'd1);
    check("err2_rdy",  32'(HREADYOUT_S), 32'd1);
    tick();
    #1;
    check("err_idle_resp", 32'(HRESP_S),     32'd0);
    check("err_idle_rdy",  32'(HREADYOUT_S), 32'd1);

    // INCR4 burst split into four SINGLE/NONSEQ transfers
    up_addr(32'hF000_0000, 1'b0, HTRANS_NONSEQ, 3'b011);
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) up_addr(32'hF000_0000 + 32'(4 * (k + 1)), 1'b0, HTRANS_SEQ, 3'b011);
      else up_idle();
      HREADYOUT_M = 1'b1;
      HRDATA_M    = 32'h100 + 32'(k);
      #1;
      check($sformatf("b%0d_sel", k),   32'(HSEL_M),   32'd1);
      check($sformatf("b%0d_trans", k), 32'(HTRANS_M), 32'(HTRANS_NONSEQ));
      check($sformatf("b%0d_burst", k), 32'(HBURST_M), 32'(HBURST_SINGLE));
      check($sformatf("b%0d_addr", k),  HADDR_M,       32'hF000_0000 + 32'(4 * k));
      tick();
      tick();
      #1;
      check($sformatf("b%0d_rdy", k),   32'(HREADYOUT_S), 32'd1);
      check($sformatf("b%0d_rdata", k), HRDATA_S,         32'h100 + 32'(k));
      tick();
    end
    #1;
    check("b_end_sel", 32'(HSEL_M),      32'd0);
    check("b_end_rdy", 32'(HREADYOUT_S), 32'd1);

    // reset during DATA
    up_addr(32'hF000_0020, 1'b0, HTRANS_NONSEQ, 3'b000);
    tick();
    up_idle();
    tick();
    HREADYOUT_M = 1'b0;
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    HREADYOUT_M = 1'b1;
    #1;
    check("rstd_rdy",   32'(HREADYOUT_S), 32'd1);
    check("rstd_sel",   32'(HSEL_M),      32'd0);
    check("rstd_trans", 32'(HTRANS_M),    32'd0);
    check("rstd_addr",  HADDR_M,          32'd0);
    check("rstd_rdata", HRDATA_S,         32'd0);
    do_read("rd2", 32'hF000_0010, 32'h0000_55AA);

    // BUSY and deselected NONSEQ are ignored
    up_addr(32'hF000_0080, 1'b0, HTRANS_BUSY, 3'b000);
    tick();
    #1;
    check("busy_sel", 32'(HSEL_M),      32'd0);
    check("busy_rdy", 32'(HREADYOUT_S), 32'd1);
    up_addr(32'hF000_0084, 1'b0, HTRANS_NONSEQ, 3'b000);
    HSEL_S = 1'b0;
    tick();
    #1;
    check("nosel_sel",  32'(HSEL_M),      32'd0);
    check("nosel_rdy",  32'(HREADYOUT_S), 32'd1);
    check("nosel_addr", HADDR_M,          32'hF000_0010);
    up_idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
